change_dispenser_ctrl: RTL and testbench

CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

---
 rtl/change_dispenser_ctrl_if.sv | 27 ++
 rtl/change_dispenser_ctrl.sv | 124 ++++++++++++
 tb/tb_change_dispenser_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_ctrl_if.sv
// Dispense request, hopper handshake, inventory reload and status bundle for change_dispenser_ctrl.
// master drives the request/ack/load side; slave is the controller.
interface change_dispenser_ctrl_if;
  logic       start;
  logic [6:0] amount;
  logic       coin_ack;
  logic       load;
  logic [3:0] load_sel;
  logic [5:0] load_count;
  logic [3:0] eject;
  logic       busy;
  logic       done;
  logic       short;
  logic       jam;
  logic [6:0] remaining;
  logic [3:0] empty;

  modport master (
    output start, amount, coin_ack, load, load_sel, load_count,
    input  eject, busy, done, short, jam, remaining, empty
  );

  modport slave (
    input  start, amount, coin_ack, load, load_sel, load_count,
    output eject, busy, done, short, jam, remaining, empty
  );
endinterface

// File: rtl/change_dispenser_ctrl.sv
// Greedy change dispenser over dollar/quarter/dime/nickel hoppers; eject rises two cycles after start.
// Each coin waits for coin_ack high then low; no ack edge within TIMEOUT cycles parks the block in JAM.
module change_dispenser_ctrl #(
  parameter int TIMEOUT  = 1000,
  parameter int INV_INIT = 20
) (
  input logic clk,
  input logic reset,
  change_dispenser_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, DONE, JAM} stateT;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [5:0]  INV_RST   = 6'(INV_INIT);

  stateT           state;
  stateT           nextState;
  logic [6:0]      remainingQ;
  logic            shortQ;
  logic [3:0][5:0] coinInv;
  logic [15:0]     waitCnt;
  logic [1:0]      selIdx;
  logic            pickVld;
  logic [1:0]      pickIdx;
  logic            waitExpired;

  // Index order matches eject: 3 dollar, 2 quarter, 1 dime, 0 nickel.
  function automatic logic [6:0] coinValue(input logic [1:0] idx);
    case (idx)
      2'd3:    return 7'd20;
      2'd2:    return 7'd5;
      2'd1:    return 7'd2;
      default: return 7'd1;
    endcase
  endfunction

  // Largest coin that fits the balance and is in stock; never lets remaining underflow.
  always_comb begin
    pickVld = 1'b0;
    pickIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pickVld && coinInv[i] != 6'd0 && coinValue(2'(i)) <= remainingQ) begin
        pickVld = 1'b1;
        pickIdx = 2'(i);
      end
    end
  end

  assign waitExpired = (waitCnt >= WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = SELECT;
      SELECT:  nextState = (remainingQ != 7'd0 && pickVld) ? EJECT : DONE;
      EJECT: begin
        if (bus.coin_ack)     nextState = RELEASE;
        else if (waitExpired) nextState = JAM;
      end
      RELEASE: begin
        if (!bus.coin_ack)    nextState = SELECT;
        else if (waitExpired) nextState = JAM;
      end
      DONE:    nextState = IDLE;
      JAM:     nextState = JAM;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remainingQ <= 7'd0;
      shortQ     <= 1'b0;
      waitCnt    <= 16'd0;
      selIdx     <= 2'd0;
      for (int i = 0; i < 4; i++) coinInv[i] <= INV_RST;
    end else begin
      // Counter runs only while parked in EJECT/RELEASE, so every entry starts from zero.
      if ((state == EJECT || state == RELEASE) && nextState == state) waitCnt <= waitCnt + 16'd1;
      else                                                            waitCnt <= 16'd0;

      if (state == IDLE) begin
        if (bus.start) begin
          remainingQ <= bus.amount;
          shortQ     <= 1'b0;
        end
        if (bus.load) begin
          for (int i = 0; i < 4; i++) begin
            if (bus.load_sel[i]) coinInv[i] <= bus.load_count;
          end
        end
      end

      if (state == SELECT) begin
        if (pickVld) selIdx <= pickIdx;
        if (remainingQ != 7'd0 && !pickVld) shortQ <= 1'b1;
      end

      if (state == EJECT && bus.coin_ack) begin
        remainingQ <= remainingQ - coinValue(selIdx);
        if (coinInv[selIdx] != 6'd0) coinInv[selIdx] <= coinInv[selIdx] - 6'd1;
      end
    end
  end

  // eject decodes straight from state so reset drops it without waiting for a clock.
  always_comb begin
    bus.eject = 4'b0000;
    if (state == EJECT) bus.eject[selIdx] = 1'b1;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.jam       = (state == JAM);
    bus.short     = shortQ;
    bus.remaining = remainingQ;
    for (int i = 0; i < 4; i++) bus.empty[i] = (coinInv[i] == 6'd0);
  end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed bench for change_dispenser_ctrl: greedy order, shortfall, zero amount, ignored restart,
// async reset mid-eject and hopper jam, against hand-computed expectations.
module tb_change_dispenser_ctrl;
  localparam int TIMEOUT  = 1000;
  localparam int INV_INIT = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_ctrl_if dispIf();

  change_dispenser_ctrl #(.TIMEOUT(TIMEOUT), .INV_INIT(INV_INIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dispIf)
  );

  int         assertCnt = 0;
  int         failCnt   = 0;
  logic       hopperEn  = 1'b0;
  logic [3:0] ejLog[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hopper model: logs each new eject, raises ack on the third cycle of eject, drops it once eject clears.
  initial begin
    int         ejCnt;
    logic [3:0] lastEj;
    ejCnt           = 0;
    lastEj          = 4'b0000;
    dispIf.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (dispIf.eject != 4'b0000 && lastEj == 4'b0000) ejLog.push_back(dispIf.eject);
      lastEj = dispIf.eject;
      if (hopperEn) begin
        if (dispIf.eject != 4'b0000 && !dispIf.coin_ack) begin
          if (ejCnt == 2) dispIf.coin_ack = 1'b1;
          else            ejCnt++;
        end else if (dispIf.eject == 4'b0000 && dispIf.coin_ack) begin
          dispIf.coin_ack = 1'b0;
          ejCnt           = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the posedge that sampled start (state is SELECT).
  task automatic startDispense(input logic [6:0] amt);
    dispIf.start  = 1'b1;
    dispIf.amount = amt;
    tick(1);
    dispIf.start  = 1'b0;
  endtask

  task automatic waitIdle(input string tag, output int doneCnt);
    logic timedOut;
    timedOut = 1'b1;
    doneCnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      if (dispIf.done) doneCnt++;
      if (!dispIf.busy) begin
        timedOut = 1'b0;
        break;
      end
      tick(1);
    end
    checkVal({tag, "_timeout"}, 32'(timedOut), 32'd0);
  endtask

  initial begin
    int         doneCnt;
    int         base;
    logic [3:0] exp1[5];
    exp1 = '{4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0001};

    dispIf.start      = 1'b0;
    dispIf.amount     = 7'd0;
    dispIf.load       = 1'b0;
    dispIf.load_sel   = 4'b0000;
    dispIf.load_count = 6'd0;
    reset = 1'b1;
    #12;
    checkVal("rst_eject",     32'(dispIf.eject),     32'd0);
    checkVal("rst_busy",      32'(dispIf.busy),      32'd0);
    checkVal("rst_done",      32'(dispIf.done),      32'd0);
    checkVal("rst_short",     32'(dispIf.short),     32'd0);
    checkVal("rst_jam",       32'(dispIf.jam),       32'd0);
    checkVal("rst_remaining", 32'(dispIf.remaining), 32'd0);
    checkVal("rst_empty",     32'(dispIf.empty),     32'd0);
    checkVal("rst_inv0",      32'(dut.coinInv[0]),   32'(INV_INIT));
    reset = 1'b0;
    tick(2);

    // 33 = 20 + 5 + 5 + 2 + 1
    hopperEn = 1'b1;
    base = ejLog.size();
    startDispense(7'd33);
    checkVal("t1_select_eject", 32'(dispIf.eject), 32'd0);
    checkVal("t1_select_busy",  32'(dispIf.busy),  32'd1);
    tick(1);
    checkVal("t1_eject_latency", 32'(dispIf.eject), 32'b1000);
    waitIdle("t1", doneCnt);
    checkVal("t1_done_pulses", 32'(doneCnt), 32'd1);
    checkVal("t1_coin_count",  32'(ejLog.size() - base), 32'd5);
    for (int k = 0; k < 5; k++)
      checkVal($sformatf("t1_coin%0d", k), 32'(ejLog[base + k]), 32'(exp1[k]));
    checkVal("t1_remaining", 32'(dispIf.remaining), 32'd0);
    checkVal("t1_short",     32'(dispIf.short),     32'd0);
    checkVal("t1_inv_dollar",  32'(dut.coinInv[3]), 32'd19);
    checkVal("t1_inv_quarter", 32'(dut.coinInv[2]), 32'd18);
    checkVal("t1_inv_dime",    32'(dut.coinInv[1]), 32'd19);
    checkVal("t1_inv_nickel",  32'(dut.coinInv[0]), 32'd19);
    tick(2);

    // Zero amount: SELECT then DONE, no coin.
    base = ejLog.size();
    startDispense(7'd0);
    checkVal("t4_done_early", 32'(dispIf.done), 32'd0);
    tick(1);
    checkVal("t4_done_pulse", 32'(dispIf.done),  32'd1);
    checkVal("t4_eject",      32'(dispIf.eject), 32'd0);
    tick(1);
    checkVal("t4_done_clear", 32'(dispIf.done),  32'd0);
    checkVal("t4_busy",       32'(dispIf.busy),  32'd0);
    checkVal("t4_short",      32'(dispIf.short), 32'd0);
    checkVal("t4_no_coin",    32'(ejLog.size() - base), 32'd0);
    tick(2);

    // 7 = 5 + 2; a second start of 20 mid-dispense must be ignored.
    base = ejLog.size();
    startDispense(7'd7);
    tick(1);
    checkVal("t6_first_eject", 32'(dispIf.eject), 32'b0100);
    dispIf.start  = 1'b1;
    dispIf.amount = 7'd20;
    tick(1);
    dispIf.start  = 1'b0;
    checkVal("t6_remaining_mid", 32'(dispIf.remaining), 32'd7);
    waitIdle("t6", doneCnt);
    checkVal("t6_done_pulses", 32'(doneCnt), 32'd1);
    checkVal("t6_coin_count",  32'(ejLog.size() - base), 32'd2);
    checkVal("t6_coin0", 32'(ejLog[base]),     32'b0100);
    checkVal("t6_coin1", 32'(ejLog[base + 1]), 32'b0010);
    checkVal("t6_remaining", 32'(dispIf.remaining), 32'd0);
    tick(2);

    // Empty the big hoppers, then reload nickels to 2 in the same cycle as start of 3.
    dispIf.load       = 1'b1;
    dispIf.load_sel   = 4'b1110;
    dispIf.load_count = 6'd0;
    tick(1);
    checkVal("t2_empty_after_load", 32'(dispIf.empty), 32'b1110);
    base = ejLog.size();
    dispIf.load_sel   = 4'b0001;
    dispIf.load_count = 6'd2;
    startDispense(7'd3);
    dispIf.load = 1'b0;
    waitIdle("t2", doneCnt);
    checkVal("t2_coin_count", 32'(ejLog.size() - base), 32'd2);
    checkVal("t2_coin0", 32'(ejLog[base]),     32'b0001);
    checkVal("t2_coin1", 32'(ejLog[base + 1]), 32'b0001);
    checkVal("t2_short",     32'(dispIf.short),     32'd1);
    checkVal("t2_remaining", 32'(dispIf.remaining), 32'd1);
    checkVal("t2_empty",     32'(dispIf.empty),     32'b1111);
    tick(3);
    checkVal("t2_short_held", 32'(dispIf.short), 32'd1);

    // Async reset while the dollar hopper is requested.
    hopperEn = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick(1);
    startDispense(7'd20);
    tick(1);
    checkVal("t5_eject_dollar", 32'(dispIf.eject), 32'b1000);
    #3 reset = 1'b1;
    #1;
    checkVal("t5_eject_async", 32'(dispIf.eject),   32'd0);
    checkVal("t5_busy",        32'(dispIf.busy),    32'd0);
    checkVal("t5_inv_dollar",  32'(dut.coinInv[3]), 32'(INV_INIT));
    checkVal("t5_remaining",   32'(dispIf.remaining), 32'd0);
    tick(1);
    #2 reset = 1'b0;
    tick(1);

    // Jam: hopper never acks.
    startDispense(7'd5);
    tick(1);
    checkVal("t3_eject_quarter", 32'(dispIf.eject), 32'b0100);
    tick(TIMEOUT - 10);
    checkVal("t3_no_jam_early", 32'(dispIf.jam), 32'd0);
    tick(15);
    checkVal("t3_jam",       32'(dispIf.jam),       32'd1);
    checkVal("t3_eject",     32'(dispIf.eject),     32'd0);
    checkVal("t3_busy",      32'(dispIf.busy),      32'd1);
    checkVal("t3_remaining", 32'(dispIf.remaining), 32'd5);
    dispIf.load       = 1'b1;
    dispIf.load_sel   = 4'b0100;
    dispIf.load_count = 6'd3;
    startDispense(7'd1);
    dispIf.load = 1'b0;
    tick(3);
    checkVal("t3_jam_sticky",     32'(dispIf.jam),       32'd1);
    checkVal("t3_busy_sticky",    32'(dispIf.busy),      32'd1);
    checkVal("t3_start_ignored",  32'(dispIf.remaining), 32'd5);
    checkVal("t3_eject_held_off", 32'(dispIf.eject),     32'd0);
    checkVal("t3_load_ignored",   32'(dut.coinInv[2]),   32'(INV_INIT));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
